// File: rtl/hamming_pkg.sv
// ============================================================================
//  Module   : hamming_pkg
//  Brief    : Shared Hamming sizing and position helpers for the ECC datapath.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package hamming_pkg;

  localparam int INJ_POS_W = 8;

  // Smallest r with 2^r >= data_w + r + 1.
  function automatic int calc_r(input int data_w);
    int r;
    r = 0;
    for (int i = 1; i < 8; i++) begin
      if (r == 0 && (1 << i) >= data_w + i + 1) r = i;
    end
    return r;
  endfunction

  function automatic bit is_pow2(input int pos);
    return (pos > 0) && ((pos & (pos - 1)) == 0);
  endfunction

  function automatic int cw_width(input int data_w, input bit secded);
    return data_w + calc_r(data_w) + (secded ? 1 : 0);
  endfunction

  // 1-based codeword position of data bit j (0-based).
  function automatic int data_pos(input int j);
    int cnt;
    int pos;
    cnt = 0;
    pos = 0;
    for (int p = 1; p < 256; p++) begin
      if (pos == 0 && !is_pow2(p)) begin
        if (cnt == j) pos = p;
        cnt++;
      end
    end
    return pos;
  endfunction

endpackage

`default_nettype wire

// File: rtl/hamming_enc_core.sv
// ============================================================================
//  Module   : hamming_enc_core
//  Brief    : Combinational Hamming encoder, optional overall parity MSB.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hamming_enc_core
  import hamming_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter bit SECDED = 1'b0,
  localparam int CW_W = cw_width(DATA_W, SECDED)
) (
  input  logic [DATA_W-1:0] i_data,
  output logic [CW_W-1:0]   o_cw
);

  localparam int R_W    = calc_r(DATA_W);
  localparam int BASE_W = DATA_W + R_W;

  // Data-bearing positions covered by parity bit 2^k.
  function automatic logic [BASE_W-1:0] cov_mask(input int k);
    logic [BASE_W-1:0] m;
    m = '0;
    for (int p = 1; p <= BASE_W; p++) begin
      if (((p >> k) & 1) == 1 && !is_pow2(p)) m[p-1] = 1'b1;
    end
    return m;
  endfunction

  logic [BASE_W-1:0] w_placed;
  logic [BASE_W-1:0] w_base;
  logic [R_W-1:0]    w_par;

  generate
    for (genvar k = 0; k < R_W; k++) begin : g_pslot
      assign w_placed[(1 << k) - 1] = 1'b0;
      assign w_par[k] = ^(w_placed & cov_mask(k));
    end
    for (genvar j = 0; j < DATA_W; j++) begin : g_dslot
      assign w_placed[data_pos(j) - 1] = i_data[j];
    end
  endgenerate

  always_comb begin
    w_base = w_placed;
    for (int k = 0; k < R_W; k++) begin
      w_base[(1 << k) - 1] = w_par[k];
    end
  end

  generate
    if (SECDED) begin : g_secded
      assign o_cw = {^w_base, w_base};
    end else begin : g_plain
      assign o_cw = w_base;
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/hamming_stream_encoder.sv
// ============================================================================
//  Module   : hamming_stream_encoder
//  Brief    : Streaming Hamming encoder, 2-entry output buffer, one-shot error
//             injection and output word counter. HAMMING_SECDED_EN adds an
//             overall even-parity MSB.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hamming_stream_encoder
  import hamming_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int CNT_W  = 16,
`ifdef HAMMING_SECDED_EN
  localparam bit SECDED = 1'b1,
`else
  localparam bit SECDED = 1'b0,
`endif
  localparam int CW_W = cw_width(DATA_W, SECDED)
) (
  input  logic                 clk_enc,
  input  logic                 rst_enc,
  input  logic [DATA_W-1:0]    enc_data,
  input  logic                 enc_valid,
  output logic                 enc_ready,
  output logic [CW_W-1:0]      codeword_out,
  output logic                 out_valid,
  input  logic                 out_ready,
  input  logic                 inj_arm,
  input  logic [INJ_POS_W-1:0] inj_pos,
  output logic                 inj_armed,
  output logic [CNT_W-1:0]     word_cnt
);

  localparam logic [INJ_POS_W-1:0] C_MAX_POS = INJ_POS_W'(CW_W);
  localparam logic [CW_W-1:0]      C_ONE     = CW_W'(1);

  logic [CW_W-1:0]      r_head;
  logic [CW_W-1:0]      r_tail;
  logic [1:0]           r_occ;
  logic                 r_inj_armed;
  logic [INJ_POS_W-1:0] r_inj_pos;
  logic [CNT_W-1:0]     r_word_cnt;

  logic [CW_W-1:0] w_enc_cw;
  logic [CW_W-1:0] w_flip;
  logic [CW_W-1:0] w_in_cw;
  logic            w_accept;
  logic            w_release;
  logic            w_arm_ok;

  hamming_enc_core #(
    .DATA_W (DATA_W),
    .SECDED (SECDED)
  ) u_core (
    .i_data (enc_data),
    .o_cw   (w_enc_cw)
  );

  assign enc_ready    = (r_occ != 2'd2) && !rst_enc;
  assign out_valid    = (r_occ != 2'd0);
  assign codeword_out = r_head;
  assign inj_armed    = r_inj_armed;
  assign word_cnt     = r_word_cnt;

  assign w_accept  = enc_valid && enc_ready;
  assign w_release = out_valid && out_ready;
  assign w_arm_ok  = inj_arm && (inj_pos != '0) && (inj_pos <= C_MAX_POS);
  assign w_flip    = r_inj_armed ? (C_ONE << (r_inj_pos - 1'b1)) : '0;
  assign w_in_cw   = w_enc_cw ^ w_flip;

  always_ff @(posedge clk_enc) begin
    if (rst_enc) begin
      r_head      <= '0;
      r_tail      <= '0;
      r_occ       <= 2'd0;
      r_inj_armed <= 1'b0;
      r_inj_pos   <= '0;
      r_word_cnt  <= '0;
    end else begin
      // Head is the output register; tail only fills when head is stalled.
      case ({w_accept, w_release})
        2'b11: r_head <= w_in_cw;
        2'b10: begin
          if (r_occ == 2'd0) r_head <= w_in_cw;
          else               r_tail <= w_in_cw;
          r_occ <= r_occ + 2'd1;
        end
        2'b01: begin
          r_head <= r_tail;
          r_occ  <= r_occ - 2'd1;
        end
        default: ;
      endcase

      if (w_release) r_word_cnt <= r_word_cnt + CNT_W'(1);

      // A same-cycle arm wins over the clear so it targets the next accept.
      if (w_accept) r_inj_armed <= 1'b0;
      if (w_arm_ok) begin
        r_inj_armed <= 1'b1;
        r_inj_pos   <= inj_pos;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_hamming_stream_encoder.sv
// ============================================================================
//  Module   : tb_hamming_stream_encoder
//  Brief    : Directed checks of hamming_stream_encoder (DATA_W=4 and 11).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hamming_stream_encoder;

`ifdef HAMMING_SECDED_EN
  localparam int CW4  = 8;
  localparam int CW11 = 16;
  localparam logic [CW4-1:0] E_1011      = 8'h55;
  localparam logic [CW4-1:0] E_0001      = 8'h87;
  localparam logic [CW4-1:0] E_0110      = 8'h33;
  localparam logic [CW4-1:0] E_1111      = 8'hFF;
  localparam logic [CW4-1:0] E_1000      = 8'h4B;
  localparam logic [CW4-1:0] E_0100      = 8'hAA;
  localparam logic [CW4-1:0] E_1011_P1   = 8'h54;
  localparam logic [CW4-1:0] E_1011_PTOP = 8'hD5;
`else
  localparam int CW4  = 7;
  localparam int CW11 = 15;
  localparam logic [CW4-1:0] E_1011      = 7'h55;
  localparam logic [CW4-1:0] E_0001      = 7'h07;
  localparam logic [CW4-1:0] E_0110      = 7'h33;
  localparam logic [CW4-1:0] E_1111      = 7'h7F;
  localparam logic [CW4-1:0] E_1000      = 7'h4B;
  localparam logic [CW4-1:0] E_0100      = 7'h2A;
  localparam logic [CW4-1:0] E_1011_P1   = 7'h54;
  localparam logic [CW4-1:0] E_1011_PTOP = 7'h15;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic [3:0]     a_data;
  logic           a_valid, a_ready, a_ovalid, a_oready, a_armed;
  logic [CW4-1:0] a_cw;
  logic [15:0]    a_cnt;
  logic           inj_arm;
  logic [7:0]     inj_pos;

  logic [10:0]     b_data;
  logic            b_valid, b_ready, b_ovalid, b_oready, b_armed;
  logic [CW11-1:0] b_cw;
  logic [3:0]      b_cnt;
  logic            b_inj_arm;
  logic [7:0]      b_inj_pos;

  int n_vec = 0;
  int n_err = 0;
  int n_hs  = 0;
  logic [CW11-1:0] q[$];
  logic [CW11-1:0] exp_b;

  logic [3:0]     d3 [3] = '{4'b0001, 4'b0110, 4'b1111};
  logic [CW4-1:0] e3 [3] = '{E_0001, E_0110, E_1111};

  hamming_stream_encoder #(.DATA_W(4), .CNT_W(16)) u_dut_a (
    .clk_enc(clk), .rst_enc(rst), .enc_data(a_data), .enc_valid(a_valid),
    .enc_ready(a_ready), .codeword_out(a_cw), .out_valid(a_ovalid),
    .out_ready(a_oready), .inj_arm(inj_arm), .inj_pos(inj_pos),
    .inj_armed(a_armed), .word_cnt(a_cnt)
  );

  hamming_stream_encoder #(.DATA_W(11), .CNT_W(4)) u_dut_b (
    .clk_enc(clk), .rst_enc(rst), .enc_data(b_data), .enc_valid(b_valid),
    .enc_ready(b_ready), .codeword_out(b_cw), .out_valid(b_ovalid),
    .out_ready(b_oready), .inj_arm(b_inj_arm), .inj_pos(b_inj_pos),
    .inj_armed(b_armed), .word_cnt(b_cnt)
  );

  function automatic logic [CW11-1:0] ref11(input logic [10:0] d);
    logic [15:0] cw;
    logic        b;
    int          j;
    cw = '0;
    j  = 0;
    for (int p = 1; p <= 15; p++) begin
      if ((p & (p - 1)) != 0) begin
        cw[p-1] = d[j];
        j++;
      end
    end
    for (int k = 0; k < 4; k++) begin
      b = 1'b0;
      for (int p = 1; p <= 15; p++) if (((p >> k) & 1) == 1) b ^= cw[p-1];
      cw[(1 << k) - 1] = b;
    end
`ifdef HAMMING_SECDED_EN
    cw[15] = ^cw[14:0];
`endif
    return CW11'(cw);
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    a_data = '0; a_valid = 1'b0; a_oready = 1'b0; inj_arm = 1'b0; inj_pos = '0;
    b_data = '0; b_valid = 1'b0; b_oready = 1'b0; b_inj_arm = 1'b0; b_inj_pos = '0;
    step();
    step();
    chk("rst_ready", a_ready, 1'b0);
    chk("rst_ovalid", a_ovalid, 1'b0);
    chk("rst_cw", a_cw, '0);
    chk("rst_armed", a_armed, 1'b0);
    chk("rst_cnt", a_cnt, '0);
    rst = 1'b0;
    #1;
    chk("ready_after_rst", a_ready, 1'b1);

    // Single word, one-cycle latency
    a_oready = 1'b1; a_data = 4'b1011; a_valid = 1'b1;
    step();
    a_valid = 1'b0;
    chk("basic_cw", a_cw, E_1011);
    chk("basic_ovalid", a_ovalid, 1'b1);
    step();
    chk("basic_cnt", a_cnt, 16'd1);
    chk("basic_empty", a_ovalid, 1'b0);

    // Back-to-back stream
    for (int i = 0; i < 3; i++) begin
      a_data = d3[i]; a_valid = 1'b1;
      step();
      chk($sformatf("stream%0d", i), a_cw, e3[i]);
    end
    a_valid = 1'b0;
    step();
    chk("stream_cnt", a_cnt, 16'd4);

    // Backpressure: third word held until the sink frees space
    a_oready = 1'b0; a_data = 4'b1000; a_valid = 1'b1;
    step();
    chk("bp_cw1", a_cw, E_1000);
    chk("bp_ready1", a_ready, 1'b1);
    a_data = 4'b0100;
    step();
    chk("bp_ready2", a_ready, 1'b0);
    chk("bp_hold2", a_cw, E_1000);
    a_data = 4'b1011;
    step();
    chk("bp_ready3", a_ready, 1'b0);
    chk("bp_hold3", a_cw, E_1000);
    chk("bp_ovalid", a_ovalid, 1'b1);
    a_oready = 1'b1;
    step();
    chk("bp_second", a_cw, E_0100);
    chk("bp_ready4", a_ready, 1'b1);
    step();
    chk("bp_third", a_cw, E_1011);
    a_valid = 1'b0;
    step();
    chk("bp_drained", a_ovalid, 1'b0);
    chk("bp_cnt", a_cnt, 16'd7);

    // Injection
    inj_pos = 8'd0; inj_arm = 1'b1;
    step();
    inj_arm = 1'b0;
    chk("inj0_ignored", a_armed, 1'b0);
    inj_pos = 8'd9; inj_arm = 1'b1;
    step();
    inj_arm = 1'b0;
    chk("inj9_ignored", a_armed, 1'b0);
    inj_pos = 8'd1; inj_arm = 1'b1;
    step();
    inj_arm = 1'b0;
    chk("inj_armed", a_armed, 1'b1);
    a_data = 4'b1011; a_valid = 1'b1;
    step();
    chk("inj_cw", a_cw, E_1011_P1);
    chk("inj_cleared", a_armed, 1'b0);
    step();
    chk("inj_next_clean", a_cw, E_1011);
    a_valid = 1'b0;
    inj_pos = 8'd1; inj_arm = 1'b1;
    step();
    inj_pos = 8'(CW4);
    step();
    inj_arm = 1'b0; a_data = 4'b1011; a_valid = 1'b1;
    step();
    chk("inj_rearm_top", a_cw, E_1011_PTOP);
    a_data = 4'b0110; inj_pos = 8'd1; inj_arm = 1'b1;
    step();
    inj_arm = 1'b0;
    chk("inj_same_cycle", a_cw, E_0110);
    chk("inj_same_armed", a_armed, 1'b1);
    a_data = 4'b1011;
    step();
    chk("inj_deferred", a_cw, E_1011_P1);
    a_valid = 1'b0;
    step();
    chk("inj_cnt", a_cnt, 16'd12);

    // Reset with two words buffered and an injection pending
    a_oready = 1'b0; a_data = 4'b0001; a_valid = 1'b1;
    step();
    step();
    a_valid = 1'b0; inj_pos = 8'd2; inj_arm = 1'b1;
    step();
    inj_arm = 1'b0;
    chk("rm_full", a_ready, 1'b0);
    chk("rm_armed_pre", a_armed, 1'b1);
    rst = 1'b1;
    step();
    chk("rm_ovalid", a_ovalid, 1'b0);
    chk("rm_cnt", a_cnt, '0);
    chk("rm_armed", a_armed, 1'b0);
    chk("rm_ready_in_rst", a_ready, 1'b0);
    rst = 1'b0;
    #1;
    chk("rm_ready", a_ready, 1'b1);
    a_oready = 1'b1;
    step();
    chk("rm_no_output", a_ovalid, 1'b0);

    // DATA_W=11 stream with mixed valid/ready against the model
    for (int i = 0; i < 48; i++) begin
      b_valid  = (i % 4) != 1;
      b_oready = (i % 3) != 0;
      b_data   = 11'(i * 173 + 5);
      #1;
      chk($sformatf("b_ready%0d", i), b_ready, q.size() < 2);
      chk($sformatf("b_ovalid%0d", i), b_ovalid, q.size() != 0);
      if (b_ovalid && b_oready && q.size() != 0) begin
        exp_b = q.pop_front();
        chk($sformatf("b_cw%0d", i), b_cw, exp_b);
        n_hs++;
      end
      if (b_valid && b_ready) q.push_back(ref11(b_data));
      step();
    end
    b_valid = 1'b0; b_oready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (q.size() != 0) begin
        chk("b_drain_ovalid", b_ovalid, 1'b1);
        exp_b = q.pop_front();
        chk("b_drain_cw", b_cw, exp_b);
        n_hs++;
      end
      step();
    end
    chk("b_empty", b_ovalid, 1'b0);
    chk("b_cnt_wrap", b_cnt, 4'(n_hs));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
